uart_receiver: RTL

- 8N1 UART receiver, the counterpart of the existing `transmitter` on the Basys3 USB-UART bridge.
- Deserialises RsRx from the host into bytes using a 16x oversampled, mid-bit sampling scheme.
- Presents each byte on a valid/ready holding register, with framing-error and overrun flags.
- Sits beside `transmitter` in top-level designs, e.g. loopback/echo, or a command receiver that triggers the "Hello, World!" sender.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 22 ++
 rtl/uart_receiver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame width and baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DATA_BITS = 8;

  // Rounded clock cycles per oversample tick.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned rate;
    rate = baud * os;
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; clear re-phases it to a line edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled mid-bit sampling into a valid/ready holding
// register with framing-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RsRx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_params
    $error("uart_receiver: invalid CLK_FREQ/BAUD/OVERSAMPLE combination");
  end

  uart_state_t          state, state_d;
  logic                 rx_meta, rx_s;
  logic [SW-1:0]        scnt, scnt_d;
  logic [BW-1:0]        bitcnt, bitcnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 armed, armed_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 data_valid_d, frame_err_d, overrun_d;
  logic                 tick, tick_clear_c;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear_c),
    .tick  (tick)
  );

  // Next-state and datapath decisions.
  always_comb begin
    state_d      = state;
    scnt_d       = scnt;
    bitcnt_d     = bitcnt;
    shreg_d      = shreg;
    armed_d      = armed;
    data_d       = data;
    data_valid_d = data_valid & ~data_ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    tick_clear_c = 1'b0;

    case (state)
      IDLE: begin
        // A start is only a high-to-low transition, never a held-low line.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed) begin
          state_d      = START;
          armed_d      = 1'b0;
          scnt_d       = '0;
          tick_clear_c = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
            scnt_d = '0;
            if (!rx_s) begin
              state_d  = DATA;
              bitcnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_d   = '0;
            shreg_d  = {rx_s, shreg[DATA_BITS-1:1]};
            bitcnt_d = bitcnt + BW'(1);
            if (bitcnt == BW'(DATA_BITS - 1)) state_d = STOP;
          end else begin
            scnt_d = scnt + SW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_d  = '0;
            state_d = IDLE;
            if (!rx_s) begin
              frame_err_d = 1'b1;
            end else if (!data_valid || data_ready) begin
              data_d       = shreg;
              data_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            scnt_d = scnt + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      scnt       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      rx_meta    <= RsRx;
      rx_s       <= rx_meta;
      scnt       <= scnt_d;
      bitcnt     <= bitcnt_d;
      shreg      <= shreg_d;
      armed      <= armed_d;
      data       <= data_d;
      data_valid <= data_valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule
